// File: rtl/mc_seq_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the datapath.
// Carries decode fields, memory handshakes, datapath controls and counters.
interface mc_seq_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic [10:0]      func;
    logic             equal;
    logic             imem_ready;
    logic             dmem_ready;
    logic             imem_req;
    logic             dmem_req;
    logic             dmem_we;
    logic             pc_en;
    logic             pc_sel;
    logic             ir_en;
    logic             rf_we;
    logic             wb_sel_rt;
    logic             wb_mem_sel;
    logic             alu_a_sel;
    logic             alu_b_sel;
    logic [10:0]      alu_op;
    logic [2:0]       state;
    logic             err;
    logic [CNT_W-1:0] retired;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        input  opcode, func, equal, imem_ready, dmem_ready,
        output imem_req, dmem_req, dmem_we, pc_en, pc_sel,
        output ir_en, rf_we, wb_sel_rt, wb_mem_sel,
        output alu_a_sel, alu_b_sel, alu_op,
        output state, err, retired, stall_cycles
    );

    modport slave (
        output opcode, func, equal, imem_ready, dmem_ready,
        input  imem_req, dmem_req, dmem_we, pc_en, pc_sel,
        input  ir_en, rf_we, wb_sel_rt, wb_mem_sel,
        input  alu_a_sel, alu_b_sel, alu_op,
        input  state, err, retired, stall_cycles
    );
endinterface

// File: rtl/mc_seq_ctrl.sv
// Multi-cycle IF/ID/EX/MEM/WB control sequencer with memory handshakes,
// per-request wait timeout and saturating retire/stall counters.
module mc_seq_ctrl #(
    parameter int DW      = 32,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input logic         clk,
    input logic         rst,
    mc_seq_ctrl_if.master bus
);
    localparam int WC_W = $clog2(TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_LIM = WC_W'(TIMEOUT - 1);
    localparam logic [10:0] ALU_ADD = 11'h020;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Datapath width and timeout must be positive; nothing else uses DW.
    if (DW < 1 || TIMEOUT < 1) begin : g_bad_param
    end

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4,
        S_ERR = 3'd7
    } state_t;

    state_t           state_q, state_d;
    logic [WC_W-1:0]  wcnt_q;
    logic             err_q;
    logic [CNT_W-1:0] retired_q;
    logic [CNT_W-1:0] stall_q;

    logic is_r, is_lw, is_sw, is_beq, is_j, legal;
    logic retire, waiting;

    logic        imem_req, dmem_req, dmem_we;
    logic        pc_en, pc_sel, ir_en, rf_we;
    logic        wb_sel_rt, wb_mem_sel;
    logic        alu_a_sel, alu_b_sel;
    logic [10:0] alu_op;

    assign is_r   = (bus.opcode == 6'b000000);
    assign is_lw  = (bus.opcode == 6'b100011);
    assign is_sw  = (bus.opcode == 6'b101011);
    assign is_beq = (bus.opcode == 6'b000100);
    assign is_j   = (bus.opcode == 6'b000010);
    assign legal  = is_r | is_lw | is_sw | is_beq | is_j;

    // Next-state and control decode; every output defaults to inactive.
    always_comb begin
        state_d    = state_q;
        retire     = 1'b0;
        waiting    = 1'b0;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        pc_en      = 1'b0;
        pc_sel     = 1'b0;
        ir_en      = 1'b0;
        rf_we      = 1'b0;
        wb_sel_rt  = 1'b0;
        wb_mem_sel = 1'b0;
        alu_a_sel  = 1'b0;
        alu_b_sel  = 1'b0;
        alu_op     = 11'h000;
        case (state_q)
            S_IF: begin
                imem_req = 1'b1;
                if (bus.imem_ready) begin
                    ir_en   = 1'b1;
                    pc_en   = 1'b1;
                    state_d = S_ID;
                end else begin
                    waiting = 1'b1;
                    if (wcnt_q == WC_LIM) state_d = S_ERR;
                end
            end
            S_ID: begin
                state_d = legal ? S_EX : S_ERR;
            end
            S_EX: begin
                unique case (1'b1)
                    is_r: begin
                        alu_a_sel = 1'b1;
                        alu_op    = bus.func;
                        state_d   = S_WB;
                    end
                    is_lw, is_sw: begin
                        alu_a_sel = 1'b1;
                        alu_b_sel = 1'b1;
                        alu_op    = ALU_ADD;
                        state_d   = S_MEM;
                    end
                    is_beq, is_j: begin
                        alu_b_sel = 1'b1;
                        alu_op    = ALU_ADD;
                        pc_sel    = 1'b1;
                        pc_en     = is_j | bus.equal;
                        retire    = 1'b1;
                        state_d   = S_IF;
                    end
                    default: state_d = S_ERR;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_sw;
                if (bus.dmem_ready) begin
                    if (is_sw) begin
                        retire  = 1'b1;
                        state_d = S_IF;
                    end else begin
                        state_d = S_WB;
                    end
                end else begin
                    waiting = 1'b1;
                    if (wcnt_q == WC_LIM) state_d = S_ERR;
                end
            end
            S_WB: begin
                rf_we      = 1'b1;
                wb_sel_rt  = is_lw;
                wb_mem_sel = is_lw;
                retire     = 1'b1;
                state_d    = S_IF;
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_ERR;
            end
        endcase
    end

    // State, wait counter and sticky error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IF;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                wcnt_q <= '0;
            end else if (waiting) begin
                wcnt_q <= wcnt_q + WC_W'(1);
            end
            if (state_d == S_ERR) err_q <= 1'b1;
        end
    end

    // Saturating retire and memory-stall counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired_q <= '0;
            stall_q   <= '0;
        end else begin
            if (retire && retired_q != CNT_MAX) begin
                retired_q <= retired_q + CNT_W'(1);
            end
            if (waiting && stall_q != CNT_MAX) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    assign bus.imem_req     = imem_req;
    assign bus.dmem_req     = dmem_req;
    assign bus.dmem_we      = dmem_we;
    assign bus.pc_en        = pc_en;
    assign bus.pc_sel       = pc_sel;
    assign bus.ir_en        = ir_en;
    assign bus.rf_we        = rf_we;
    assign bus.wb_sel_rt    = wb_sel_rt;
    assign bus.wb_mem_sel   = wb_mem_sel;
    assign bus.alu_a_sel    = alu_a_sel;
    assign bus.alu_b_sel    = alu_b_sel;
    assign bus.alu_op       = alu_op;
    assign bus.state        = state_q;
    assign bus.err          = err_q;
    assign bus.retired      = retired_q;
    assign bus.stall_cycles = stall_q;
endmodule

// File: tb/tb_mc_seq_ctrl.sv
// Bench for mc_seq_ctrl: per-instruction cycle plans from the ISA rules,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mc_seq_ctrl;
    localparam int CW = 3;
    localparam int TO = 4;
    localparam int MAXC = (1 << CW) - 1;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    localparam int S_IF = 0, S_ID = 1, S_EX = 2, S_MEM = 3, S_WB = 4, S_ERR = 7;

    localparam logic [10:0] C_IMREQ = 11'h400;
    localparam logic [10:0] C_DMREQ = 11'h200;
    localparam logic [10:0] C_DMWE  = 11'h100;
    localparam logic [10:0] C_PCEN  = 11'h080;
    localparam logic [10:0] C_PCSEL = 11'h040;
    localparam logic [10:0] C_IREN  = 11'h020;
    localparam logic [10:0] C_RFWE  = 11'h010;
    localparam logic [10:0] C_WBRT  = 11'h008;
    localparam logic [10:0] C_WBMEM = 11'h004;
    localparam logic [10:0] C_ASEL  = 11'h002;
    localparam logic [10:0] C_BSEL  = 11'h001;
    localparam logic [10:0] ADD     = 11'h020;

    logic clk = 1'b0;
    logic rst = 1'b0;

    mc_seq_ctrl_if #(.CNT_W(CW)) bus ();

    mc_seq_ctrl #(.DW(32), .CNT_W(CW), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    bit          chk = 1'b0;
    int          e_state;
    logic [10:0] e_ctl;
    logic [10:0] e_op;
    bit          e_err;
    int          e_ret, e_stall;
    int          m_ret = 0, m_stall = 0;

    task automatic chk_eq(input string nm, input longint got, input longint want);
        n_checks++;
        if (got != want) begin
            n_errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, got, want, $time);
        end
    endtask

    function automatic logic [10:0] dut_ctl();
        return {bus.imem_req, bus.dmem_req, bus.dmem_we, bus.pc_en,
                bus.pc_sel, bus.ir_en, bus.rf_we, bus.wb_sel_rt,
                bus.wb_mem_sel, bus.alu_a_sel, bus.alu_b_sel};
    endfunction

    // Per-cycle comparison of the DUT against the planned cycle.
    always @(negedge clk) begin
        if (chk) begin
            chk_eq("state", longint'(bus.state), longint'(e_state));
            chk_eq("ctl", longint'(dut_ctl()), longint'(e_ctl));
            chk_eq("alu_op", longint'(bus.alu_op), longint'(e_op));
            chk_eq("err", longint'(bus.err), longint'(e_err));
            chk_eq("retired", longint'(bus.retired), longint'(e_ret));
            chk_eq("stall", longint'(bus.stall_cycles), longint'(e_stall));
        end
    end

    function automatic logic rbit();
        return logic'($urandom_range(0, 1));
    endfunction

    // One clock of the plan: drive readies, publish expectations, advance.
    task automatic step(input int st, input logic [10:0] ctl,
                        input logic [10:0] aop, input bit er,
                        input logic imr, input logic dmr,
                        input bit st_inc, input bit ret_inc);
        bus.imem_ready = imr;
        bus.dmem_ready = dmr;
        e_state = st;
        e_ctl   = ctl;
        e_op    = aop;
        e_err   = er;
        e_ret   = m_ret;
        e_stall = m_stall;
        chk     = 1'b1;
        @(posedge clk);
        #1;
        if (st_inc && m_stall < MAXC) m_stall++;
        if (ret_inc && m_ret < MAXC) m_ret++;
    endtask

    task automatic do_reset();
        chk = 1'b0;
        rst = 1'b0;
        #1;
        chk_eq("rst_state", longint'(bus.state), 0);
        chk_eq("rst_retired", longint'(bus.retired), 0);
        chk_eq("rst_stall", longint'(bus.stall_cycles), 0);
        chk_eq("rst_err", longint'(bus.err), 0);
        chk_eq("rst_imem_req", longint'(bus.imem_req), 1);
        chk_eq("rst_dmem_req", longint'(bus.dmem_req), 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        m_ret = 0;
        m_stall = 0;
    endtask

    task automatic err_hold();
        for (int i = 0; i < 20; i++) begin
            step(S_ERR, 11'h000, 11'h000, 1'b1, rbit(), rbit(), 1'b0, 1'b0);
        end
        do_reset();
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        return op == OP_R || op == OP_LW || op == OP_SW ||
               op == OP_BEQ || op == OP_J;
    endfunction

    // Expand one instruction into its cycle plan and run it.
    task automatic exec(input logic [5:0] op, input logic [10:0] fn,
                        input logic eq, input int wi, input int wd,
                        input bit rst_mem, output int cyc);
        logic [10:0] mctl;
        cyc = 0;
        bus.opcode = op;
        bus.func   = fn;
        bus.equal  = eq;
        for (int k = 0; k < wi; k++) begin
            step(S_IF, C_IMREQ, 11'h000, 1'b0, 1'b0, rbit(), 1'b1, 1'b0);
            cyc++;
            if (k == TO - 1) begin
                err_hold();
                return;
            end
        end
        step(S_IF, C_IMREQ | C_IREN | C_PCEN, 11'h000, 1'b0,
             1'b1, rbit(), 1'b0, 1'b0);
        cyc++;
        step(S_ID, 11'h000, 11'h000, 1'b0, rbit(), rbit(), 1'b0, 1'b0);
        cyc++;
        if (!is_legal(op)) begin
            err_hold();
            return;
        end
        if (op == OP_R) begin
            step(S_EX, C_ASEL, fn, 1'b0, rbit(), rbit(), 1'b0, 1'b0);
            step(S_WB, C_RFWE, 11'h000, 1'b0, rbit(), rbit(), 1'b0, 1'b1);
            cyc += 2;
            return;
        end
        if (op == OP_BEQ || op == OP_J) begin
            step(S_EX, C_BSEL | C_PCSEL | ((op == OP_J || eq) ? C_PCEN : 11'h000),
                 ADD, 1'b0, rbit(), rbit(), 1'b0, 1'b1);
            cyc++;
            return;
        end
        step(S_EX, C_ASEL | C_BSEL, ADD, 1'b0, rbit(), rbit(), 1'b0, 1'b0);
        cyc++;
        mctl = C_DMREQ | ((op == OP_SW) ? C_DMWE : 11'h000);
        if (rst_mem) begin
            chk = 1'b0;
            bus.dmem_ready = 1'b0;
            #1;
            chk_eq("mid_state", longint'(bus.state), S_MEM);
            chk_eq("mid_dmem_req", longint'(bus.dmem_req), 1);
            rst = 1'b0;
            #1;
            chk_eq("mr_state", longint'(bus.state), 0);
            chk_eq("mr_dmem_req", longint'(bus.dmem_req), 0);
            chk_eq("mr_retired", longint'(bus.retired), 0);
            chk_eq("mr_stall", longint'(bus.stall_cycles), 0);
            @(posedge clk);
            #1;
            rst = 1'b1;
            m_ret = 0;
            m_stall = 0;
            return;
        end
        for (int k = 0; k < wd; k++) begin
            step(S_MEM, mctl, 11'h000, 1'b0, rbit(), 1'b0, 1'b1, 1'b0);
            cyc++;
            if (k == TO - 1) begin
                err_hold();
                return;
            end
        end
        step(S_MEM, mctl, 11'h000, 1'b0, rbit(), 1'b1, 1'b0, op == OP_SW);
        cyc++;
        if (op == OP_LW) begin
            step(S_WB, C_RFWE | C_WBRT | C_WBMEM, 11'h000, 1'b0,
                 rbit(), rbit(), 1'b0, 1'b1);
            cyc++;
        end
    endtask

    function automatic int rnd_wait();
        int r = $urandom_range(0, 99);
        if (r < 70) return $urandom_range(0, 2);
        if (r < 90) return TO - 1;
        return $urandom_range(TO, TO + 1);
    endfunction

    initial begin
        int cyc;
        logic [5:0] op;
        bus.opcode = 6'h0;
        bus.func = 11'h0;
        bus.equal = 1'b0;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        do_reset();

        exec(OP_R, 11'h020, 1'b0, 0, 0, 1'b0, cyc);
        chk_eq("r_cycles", cyc, 4);
        chk_eq("r_retired", longint'(bus.retired), 1);

        do_reset();
        exec(OP_LW, 11'h000, 1'b0, 2, 3, 1'b0, cyc);
        chk_eq("lw_cycles", cyc, 10);
        chk_eq("lw_stall", longint'(bus.stall_cycles), 5);

        do_reset();
        exec(OP_BEQ, 11'h000, 1'b0, 0, 0, 1'b0, cyc);
        chk_eq("beq0_cycles", cyc, 3);
        exec(OP_BEQ, 11'h000, 1'b1, 0, 0, 1'b0, cyc);
        chk_eq("beq1_cycles", cyc, 3);
        chk_eq("beq_retired", longint'(bus.retired), 2);

        exec(6'b111111, 11'h000, 1'b0, 0, 0, 1'b0, cyc);

        do_reset();
        exec(OP_R, 11'h025, 1'b0, TO, 0, 1'b0, cyc);
        exec(OP_R, 11'h025, 1'b0, TO - 1, 0, 1'b0, cyc);
        chk_eq("to_edge_cycles", cyc, 4 + TO - 1);

        do_reset();
        for (int i = 0; i < 9; i++) exec(OP_SW, 11'h0, 1'b0, 0, 0, 1'b0, cyc);
        chk_eq("sat_retired", longint'(bus.retired), 7);
        exec(OP_SW, 11'h0, 1'b0, 1, 0, 1'b1, cyc);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 10))
                0, 1: op = OP_R;
                2, 3: op = OP_LW;
                4, 5: op = OP_SW;
                6, 7: op = OP_BEQ;
                8, 9: op = OP_J;
                default: begin
                    op = 6'($urandom_range(0, 63));
                    while (is_legal(op)) op = 6'($urandom_range(0, 63));
                end
            endcase
            exec(op, 11'($urandom), rbit(), rnd_wait(), rnd_wait(),
                 $urandom_range(0, 19) == 0, cyc);
            if ($urandom_range(0, 29) == 0) do_reset();
        end

        chk = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mc_seq_ctrl.md
# mc_seq_ctrl

Parametrised multi-cycle control sequencer for the teaching CPU core, the next-generation replacement for the fixed-latency control unit. It steps each instruction through IF/ID/EX/MEM/WB and drives every datapath enable and mux select. It adds three things the current controller lacks: request/ready handshakes to variable-latency instruction and data memories, a wait-timeout error state, and saturating retire/stall performance counters. It sits between the IR/decode fields and the PC/register-file/ALU/DMEM datapath.

## Interface
- DW, 32, datapath width; reserved for the datapath side, no control logic depends on it
- CNT_W, 32, width of the performance counters
- TIMEOUT, 255, maximum wait cycles per memory request before the sequencer enters ERR (minimum 1)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- opcode  in  6  IR[31:26]
- func  in  11  IR[10:0], the ALU function field
- equal  in  1  datapath comparator: regA == regB
- imem_ready  in  1  instruction memory data valid
- dmem_ready  in  1  data memory access complete
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write
- pc_en  out  1  PC load
- pc_sel  out  1  0 = PC+4, 1 = ALU result
- ir_en  out  1  IR load
- rf_we  out  1  register file write
- wb_sel_rt  out  1  1 = write rt (IR[20:16]), 0 = write rd (IR[15:11])
- wb_mem_sel  out  1  1 = write-back from LMD, 0 = from ALU output register
- alu_a_sel  out  1  1 = reg A, 0 = NPC
- alu_b_sel  out  1  1 = immediate, 0 = reg B
- alu_op  out  11  ALU operation code
- state  out  3  current state: IF=0, ID=1, EX=2, MEM=3, WB=4, ERR=7
- err  out  1  sticky error flag
- retired  out  CNT_W  retired instruction count
- stall_cycles  out  CNT_W  memory wait-cycle count

## Operation
- Instruction classes: R-type opcode 000000; LW 100011; SW 101011; BEQ 000100; J 000010. Any other opcode is illegal.
- Registers: state, the wait counter, err, retired and stall_cycles. All control outputs are combinational from state, opcode, equal and the ready inputs. Outside the cases listed below, every control output is 0.
- IF
  - imem_req = 1.
  - On imem_ready: ir_en = 1, pc_en = 1, pc_sel = 0, go to ID.
- ID
  - Lasts one cycle.
  - Illegal opcode: go to ERR.
  - Otherwise: go to EX.
- EX, by class:
  - R-type: alu_a_sel = 1, alu_b_sel = 0, alu_op = func; go to WB.
  - LW/SW: alu_a_sel = 1, alu_b_sel = 1, alu_op = 11'h020 (ADD); go to MEM.
  - BEQ: alu_a_sel = 0, alu_b_sel = 1, alu_op = 11'h020; pc_en = equal, pc_sel = 1; go to IF and retire.
  - J: same operand selects, alu_op and pc_sel as BEQ, but pc_en = 1; go to IF and retire.
- MEM
  - dmem_req = 1; dmem_we = 1 for SW.
  - On dmem_ready: SW goes to IF and retires; LW goes to WB.
- WB
  - rf_we = 1.
  - wb_sel_rt = 1 for LW, 0 for R-type.
  - wb_mem_sel = 1 for LW, 0 for R-type.
  - Go to IF and retire.
- ERR
  - err = 1; all enables and requests 0.
  - Held until reset.
- Wait counter
  - Cleared on every state change.
  - Increments each cycle in IF or MEM while the request is not acknowledged.
  - Reaching TIMEOUT with the ready input still low: go to ERR.
  - Ready high in the same cycle the limit is reached: ready wins, normal transition.
- retired: +1 on the transition that completes an instruction.
- stall_cycles: +1 each cycle with a request high and its ready low.
- Both counters saturate at all-ones and never wrap.

## Timing
- Reset value of every output: state = IF; err = 0; retired = 0; stall_cycles = 0.
- During reset, imem_req = 1 combinationally; it is ignored until the first edge after reset deassertion.
- Latency with ready held high (zero-wait memories):
  - R-type: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ and J: 3 cycles.
- Each memory wait cycle adds exactly one cycle.
- Requests stay asserted and stable until ready; ready sampled while the request is low is ignored.
- Reset asserted mid-instruction: state returns to IF immediately (asynchronously), counters clear, and in-flight requests drop the same cycle.

## Test plan
- Zero-wait R-type, func = 11'h020 → states IF, ID, EX, WB over 4 cycles; rf_we = 1 only in WB with wb_sel_rt = 0; retired = 1.
- LW with imem_ready delayed 2 cycles and dmem_ready delayed 3 cycles → total 10 cycles; stall_cycles = 5; rf_we and wb_mem_sel = 1 in WB.
- BEQ with equal = 0, then BEQ with equal = 1 → pc_en in EX is 0, then 1 with pc_sel = 1; both take 3 cycles; retired = 2.
- Opcode 111111 → ERR one cycle after ID; err = 1; all enables stay 0 for 20 further cycles; only rst = 0 clears it.
- TIMEOUT = 4, imem_ready held low → ERR after 4 wait cycles. Repeat with imem_ready rising in that same final cycle → normal transition to ID.
- CNT_W = 3, run 9 zero-wait SW instructions → retired saturates at 7. Assert rst mid-MEM → state = IF, counters = 0, dmem_req = 0 immediately.
